// File: rtl/vt_command_encoder.sv
// rtl/vt_command_encoder.sv - serialises decoded terminal commands into a VT100 byte stream
module vt_command_encoder #(
    parameter bit          OMIT_DEFAULT = 1'b0,
    parameter logic [7:0]  ESC_CODE     = 8'h1B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_type,
    input  logic [7:0] pn1,
    input  logic [7:0] pn2,
    input  logic [7:0] pchar,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHAR, S_ESC, S_BRACKET, S_P1, S_SEMI, S_P2, S_FINAL
    } state_t;

    typedef enum logic [1:0] {
        D_HUND, D_TENS, D_UNITS
    } digit_t;

    localparam logic [3:0] T_INPUT = 4'd0;
    localparam logic [3:0] T_IND   = 4'd1;
    localparam logic [3:0] T_NEL   = 4'd2;
    localparam logic [3:0] T_RI    = 4'd3;
    localparam logic [3:0] T_CUU   = 4'd4;
    localparam logic [3:0] T_CUD   = 4'd5;
    localparam logic [3:0] T_CUF   = 4'd6;
    localparam logic [3:0] T_CUB   = 4'd7;
    localparam logic [3:0] T_CUP   = 4'd8;

    localparam logic [7:0] ASCII_0 = 8'h30;

    state_t     state;
    digit_t     dsub;
    logic [3:0] typ_q;
    logic [7:0] pn1_q, pn2_q;
    // Digits are held already converted to ASCII so they go straight onto tx_data.
    logic [7:0] p1_h, p1_t, p1_u;
    logic [7:0] p2_h, p2_t, p2_u;

    logic       is_esc_only, is_cursor, is_cup, omit;
    logic [7:0] final_char;
    logic [7:0] p1_first, p2_first;
    digit_t     p1_first_sub, p2_first_sub;

    assign busy        = (state != S_IDLE);
    assign is_esc_only = (typ_q == T_IND) || (typ_q == T_NEL) || (typ_q == T_RI);
    assign is_cursor   = (typ_q >= T_CUU) && (typ_q <= T_CUB);
    assign is_cup      = (typ_q == T_CUP);
    assign omit        = OMIT_DEFAULT &&
                         ((is_cursor && pn1_q == 8'd1) ||
                          (is_cup && pn1_q == 8'd1 && pn2_q == 8'd1));

    always_comb begin
        final_char = 8'h48;
        case (typ_q)
            T_IND:   final_char = 8'h44;
            T_NEL:   final_char = 8'h45;
            T_RI:    final_char = 8'h4D;
            T_CUU:   final_char = 8'h41;
            T_CUD:   final_char = 8'h42;
            T_CUF:   final_char = 8'h43;
            T_CUB:   final_char = 8'h44;
            default: final_char = 8'h48;
        endcase
    end

    // Leading zero digits are skipped; the units digit is always emitted.
    always_comb begin
        p1_first     = p1_u;
        p1_first_sub = D_UNITS;
        if (p1_h != ASCII_0) begin
            p1_first     = p1_h;
            p1_first_sub = D_HUND;
        end else if (p1_t != ASCII_0) begin
            p1_first     = p1_t;
            p1_first_sub = D_TENS;
        end
        p2_first     = p2_u;
        p2_first_sub = D_UNITS;
        if (p2_h != ASCII_0) begin
            p2_first     = p2_h;
            p2_first_sub = D_HUND;
        end else if (p2_t != ASCII_0) begin
            p2_first     = p2_t;
            p2_first_sub = D_TENS;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            dsub      <= D_HUND;
            cmd_ready <= 1'b1;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            typ_q     <= 4'd0;
            pn1_q     <= 8'd0;
            pn2_q     <= 8'd0;
            p1_h      <= 8'd0;
            p1_t      <= 8'd0;
            p1_u      <= 8'd0;
            p2_h      <= 8'd0;
            p2_t      <= 8'd0;
            p2_u      <= 8'd0;
        end else if (state == S_IDLE) begin
            if (!cmd_ready) begin
                // Only reached after an invalid command: one dead cycle, then ready again.
                cmd_ready <= 1'b1;
            end else if (cmd_valid) begin
                cmd_ready <= 1'b0;
                typ_q     <= cmd_type;
                pn1_q     <= pn1;
                pn2_q     <= pn2;
                p1_h      <= ASCII_0 + pn1 / 8'd100;
                p1_t      <= ASCII_0 + (pn1 / 8'd10) % 8'd10;
                p1_u      <= ASCII_0 + pn1 % 8'd10;
                p2_h      <= ASCII_0 + pn2 / 8'd100;
                p2_t      <= ASCII_0 + (pn2 / 8'd10) % 8'd10;
                p2_u      <= ASCII_0 + pn2 % 8'd10;
                if (cmd_type == T_INPUT) begin
                    state    <= S_CHAR;
                    tx_data  <= pchar;
                    tx_valid <= 1'b1;
                end else if (cmd_type <= T_CUP) begin
                    state    <= S_ESC;
                    tx_data  <= ESC_CODE;
                    tx_valid <= 1'b1;
                end
            end
        end else if (tx_valid && tx_ready) begin
            case (state)
                S_ESC: begin
                    if (is_esc_only) begin
                        state   <= S_FINAL;
                        tx_data <= final_char;
                    end else begin
                        state   <= S_BRACKET;
                        tx_data <= 8'h5B;
                    end
                end
                S_BRACKET: begin
                    if (omit) begin
                        state   <= S_FINAL;
                        tx_data <= final_char;
                    end else begin
                        state   <= S_P1;
                        dsub    <= p1_first_sub;
                        tx_data <= p1_first;
                    end
                end
                S_P1: begin
                    case (dsub)
                        D_HUND: begin
                            dsub    <= D_TENS;
                            tx_data <= p1_t;
                        end
                        D_TENS: begin
                            dsub    <= D_UNITS;
                            tx_data <= p1_u;
                        end
                        default: begin
                            if (is_cup) begin
                                state   <= S_SEMI;
                                tx_data <= 8'h3B;
                            end else begin
                                state   <= S_FINAL;
                                tx_data <= final_char;
                            end
                        end
                    endcase
                end
                S_SEMI: begin
                    state   <= S_P2;
                    dsub    <= p2_first_sub;
                    tx_data <= p2_first;
                end
                S_P2: begin
                    case (dsub)
                        D_HUND: begin
                            dsub    <= D_TENS;
                            tx_data <= p2_t;
                        end
                        D_TENS: begin
                            dsub    <= D_UNITS;
                            tx_data <= p2_u;
                        end
                        default: begin
                            state   <= S_FINAL;
                            tx_data <= 8'h48;
                        end
                    endcase
                end
                default: begin
                    // CHAR and FINAL: last byte taken, return to IDLE.
                    state     <= S_IDLE;
                    tx_valid  <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vt_command_encoder.sv
// tb/tb_vt_command_encoder.sv - randomized self-checking bench for vt_command_encoder
module tb_vt_command_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic [3:0] cmd_type  [2];
    logic [7:0] pn1       [2];
    logic [7:0] pn2       [2];
    logic [7:0] pchar     [2];
    logic [7:0] tx_data   [2];
    logic       tx_valid  [2];
    logic       tx_ready  [2];
    logic       busy      [2];

    always #5 clk = ~clk;

    vt_command_encoder #(.OMIT_DEFAULT(1'b0), .ESC_CODE(8'h1B)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_type(cmd_type[0]),
        .pn1(pn1[0]), .pn2(pn2[0]), .pchar(pchar[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0])
    );

    vt_command_encoder #(.OMIT_DEFAULT(1'b1), .ESC_CODE(8'h1B)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_type(cmd_type[1]),
        .pn1(pn1[1]), .pn2(pn2[1]), .pchar(pchar[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .busy(busy[1])
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_dec(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    endfunction

    // Reference: the byte string a VT100 parser expects for this command.
    function automatic void model(input bit omit, input int t, input int a, input int b, input int c);
        string esc_final;
        string cur_final;
        esc_final = "DEM";
        cur_final = "ABCD";
        exp_q.delete();
        if (t == 0) begin
            exp_q.push_back(8'(c));
        end else if (t <= 3) begin
            exp_q.push_back(8'h1B);
            exp_q.push_back(8'(esc_final[t-1]));
        end else if (t <= 7) begin
            exp_q.push_back(8'h1B);
            exp_q.push_back("[");
            if (!(omit && a == 1)) push_dec(a);
            exp_q.push_back(8'(cur_final[t-4]));
        end else if (t == 8) begin
            exp_q.push_back(8'h1B);
            exp_q.push_back("[");
            if (!(omit && a == 1 && b == 1)) begin
                push_dec(a);
                exp_q.push_back(";");
                push_dec(b);
            end
            exp_q.push_back("H");
        end
    endfunction

    task automatic run_cmd(input int s, input int t, input int a, input int b, input int c,
                           input bit bp, input bit b2b);
        int n;
        int cyc;
        bit held;
        logic [7:0] hd;
        n = 0;
        while (!cmd_ready[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rdy_before", cmd_ready[s], 1);
        model(s[0], t, a, b, c);
        cmd_valid[s] = 1'b1;
        cmd_type[s]  = 4'(t);
        pn1[s]       = 8'(a);
        pn2[s]       = 8'(b);
        pchar[s]     = 8'(c);
        @(negedge clk);
        cmd_valid[s] = $urandom_range(0, 1);
        cmd_type[s]  = 4'($urandom);
        pn1[s]       = 8'($urandom);
        pn2[s]       = 8'($urandom);
        pchar[s]     = 8'($urandom);
        check("rdy_after_accept", cmd_ready[s], 0);
        if (exp_q.size() == 0) begin
            check("inv_txv", tx_valid[s], 0);
            check("inv_busy", busy[s], 0);
            @(negedge clk);
            check("inv_rdy_back", cmd_ready[s], 1);
            check("inv_txv2", tx_valid[s], 0);
            cmd_valid[s] = 1'b0;
            return;
        end
        got_q.delete();
        cyc  = 0;
        held = 1'b0;
        hd   = 8'h00;
        while (got_q.size() < exp_q.size() && cyc < 200) begin
            check("txv_on", tx_valid[s], 1);
            check("busy_on", busy[s], 1);
            check("rdy_low", cmd_ready[s], 0);
            if (held) check("hold_data", tx_data[s], hd);
            tx_ready[s] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid[s] && tx_ready[s]) begin
                got_q.push_back(tx_data[s]);
                held = 1'b0;
            end else if (tx_valid[s]) begin
                held = 1'b1;
                hd   = tx_data[s];
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready[s]  = 1'b0;
        cmd_valid[s] = 1'b0;
        check("nbytes", got_q.size(), exp_q.size());
        if (b2b) check("b2b_cycles", cyc, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("byte%0d_t%0d", i, t), got_q[i], exp_q[i]);
        check("rdy_end", cmd_ready[s], 1);
        check("txv_end", tx_valid[s], 0);
        check("busy_end", busy[s], 0);
    endtask

    function automatic int pick_pn();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return $urandom_range(2, 9);
            3:       return $urandom_range(10, 99);
            4:       return $urandom_range(100, 255);
            default: return $urandom_range(0, 255);
        endcase
    endfunction

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b1;
            cmd_type[i]  = 4'd8;
            pn1[i]       = 8'd12;
            pn2[i]       = 8'd5;
            pchar[i]     = 8'h41;
            tx_ready[i]  = 1'b1;
        end
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("rst_rdy", cmd_ready[i], 1);
                check("rst_txv", tx_valid[i], 0);
                check("rst_txd", tx_data[i], 8'h00);
                check("rst_busy", busy[i], 0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            tx_ready[i]  = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);

        run_cmd(0, 0, 0, 0, 8'h41, 0, 1);
        run_cmd(0, 8, 12, 5, 0, 0, 1);
        run_cmd(0, 6, 0, 0, 0, 0, 1);
        run_cmd(0, 5, 255, 0, 0, 0, 1);
        run_cmd(0, 4, 100, 0, 0, 0, 1);
        run_cmd(0, 8, 1, 1, 0, 0, 1);
        run_cmd(0, 0, 0, 0, 8'h1B, 0, 1);
        run_cmd(0, 3, 0, 0, 0, 1, 0);
        run_cmd(1, 4, 1, 0, 0, 0, 1);
        run_cmd(1, 8, 1, 1, 0, 0, 1);
        run_cmd(1, 8, 1, 3, 0, 0, 1);
        run_cmd(1, 8, 7, 1, 0, 0, 1);
        run_cmd(1, 7, 7, 0, 0, 1, 0);
        run_cmd(0, 12, 3, 4, 0, 0, 0);
        run_cmd(1, 15, 1, 1, 0, 0, 0);

        // Abort a CUP after its third byte has been taken.
        cmd_valid[0] = 1'b1;
        cmd_type[0]  = 4'd8;
        pn1[0]       = 8'd123;
        pn2[0]       = 8'd45;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        tx_ready[0]  = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_abort_txv", tx_valid[0], 1);
        check("pre_abort_byte3", tx_data[0], 8'h32);
        rst = 1'b0;
        #1;
        check("abort_txv", tx_valid[0], 0);
        check("abort_busy", busy[0], 0);
        check("abort_rdy", cmd_ready[0], 1);
        tx_ready[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_cmd(0, 5, 42, 0, 0, 0, 1);

        for (int k = 0; k < 60; k++) begin
            int t;
            t = $urandom_range(0, 11);
            if (t > 8) t = $urandom_range(9, 15);
            run_cmd(k % 2, t, pick_pn(), pick_pn(), $urandom_range(0, 255),
                    1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
